tsc_capture_buffer: RTL and testbench
=====================================

# tsc_capture_buffer

Parametrised trigger-surround capture buffer for the TSC datapath. It continuously records ADC samples into a circular memory once armed. On a programmable threshold event it freezes a window holding a runtime-selected number of pre-trigger samples, the trigger sample, and the remaining post-trigger samples. The window is then streamed out oldest-first through a read handshake. It sits between the ADC sample interface and the host readout logic.

## Interface
- DATA_W, 8, sample width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W samples (32 default)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- arm  in  1  start a capture; honoured only in IDLE
- abort  in  1  return to IDLE from any state; highest priority
- pre_len  in  ADDR_W  pre-trigger sample count (0..DEPTH-1); latched on accepted arm
- trig_level  in  DATA_W  unsigned threshold; latched on accepted arm
- trig_edge  in  1  0 = level trigger, 1 = rising-crossing trigger; latched on accepted arm
- adc_req  in  1  sample strobe; adc_dat valid this cycle
- adc_dat  in  DATA_W  ADC sample, unsigned
- rd_req  in  1  request next readout sample; honoured only in READ
- busy  out  1  high in PRE, TRIG_WAIT, POST
- trig  out  1  one-cycle pulse, cycle after trigger sample accepted
- cap_rdy  out  1  high while in READ
- rd_vld  out  1  rd_dat valid, one cycle per honoured rd_req
- rd_dat  out  DATA_W  readout sample
- rd_last  out  1  with rd_vld on final (DEPTH-th) sample

## Operation
- States: IDLE, PRE, TRIG_WAIT, POST, READ. Reset: IDLE; all outputs 0; wr_ptr, counters, and prev sample 0. Memory contents are not reset.
- IDLE: arm latches configuration and clears prev sample and fill counter. Next state is PRE, or TRIG_WAIT if pre_len = 0.
- Write rule in PRE/TRIG_WAIT/POST: each adc_req writes adc_dat to mem[wr_ptr]; wr_ptr increments mod DEPTH (natural ADDR_W wrap); prev ← adc_dat.
- PRE: each write increments the fill counter. The write that makes fill = pre_len moves to TRIG_WAIT. Triggers are not evaluated in PRE.
- TRIG_WAIT: each write is evaluated against the trigger. Level trigger: adc_dat > trig_level. Edge trigger: adc_dat > trig_level and prev <= trig_level. Comparison is unsigned, strict.
- On trigger: trig_ptr ← wr_ptr; post counter ← DEPTH-1-pre_len. Next state is POST, or READ directly if post count = 0.
- POST: each write decrements the post counter. The write that brings it to 0 moves to READ. Triggers are ignored.
- READ: rd_ptr starts at trig_ptr - pre_len mod DEPTH, and the read count starts at 0. Each rd_req reads mem[rd_ptr], increments rd_ptr (with wrap) and the count. The DEPTH-th honoured rd_req returns to IDLE. adc_req is ignored.
- abort: next state IDLE; no further writes or reads. A read already issued still completes its rd_vld the next cycle. abort together with arm in IDLE leaves the block in IDLE.
- arm outside IDLE, and rd_req outside READ, are ignored with no side effects.

## Timing
- Write and state transition occur on the same edge that samples adc_req.
- trig: asserted for exactly one cycle, the cycle after the triggering edge.
- Read latency: 1 cycle. An rd_req honoured at edge N gives rd_vld/rd_dat at N+1. Back-to-back rd_req gives one sample per cycle. rd_vld falls the cycle after rd_req deasserts.
- rd_last coincides with rd_vld of the final sample. The block is already in IDLE in that cycle, so arm may be accepted then.
- cap_rdy falls on the edge that honours the final rd_req.
- Capture window is always exactly DEPTH samples: pre_len pre, 1 trigger, DEPTH-1-pre_len post.

## Test plan
- Level trigger, DEPTH=32, pre_len=8, trig_level=0xD5, ramp 0x00,0x01,… with 0xD6 injected as sample 20 → trig pulse once. 32 reads return 8 pre samples (12..19), 0xD6, then the next 23 samples; rd_last on read 32.
- Edge trigger, trig_level=0x80, input held at 0x90 after PRE → no trigger. Drop to 0x70 then 0x91 → trigger on 0x91. The pre-trigger window wraps correctly across address 31→0.
- pre_len=0 → arm goes straight to TRIG_WAIT, and first read returns the trigger sample. pre_len=31 → READ entered on the trigger write, and last read returns the trigger sample.
- abort in POST, then abort in mid-READ after 5 reads → IDLE next cycle, busy/cap_rdy low, and no further rd_vld after the in-flight one. Re-arm succeeds.
- Gapped adc_req (every 3rd cycle) and gapped rd_req → identical readout to the contiguous case. arm/rd_req in wrong states are ignored.
- Async rst asserted mid-POST and mid-READ → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/tsc_capture_buffer_if.sv
// Signal bundle between the ADC/host side and the TSC trigger-surround
// capture buffer. The master side drives control, samples and read requests.
// The slave side (the capture buffer) returns status and readout data.
interface tsc_capture_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    // Control and configuration
    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] pre_len;
    logic [DATA_W-1:0] trig_level;
    logic              trig_edge;

    // ADC sample stream
    logic              adc_req;
    logic [DATA_W-1:0] adc_dat;

    // Readout handshake
    logic              rd_req;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_dat;
    logic              rd_last;

    // Status
    logic              busy;
    logic              trig;
    logic              cap_rdy;

    modport master (
        output arm, abort, pre_len, trig_level, trig_edge,
        output adc_req, adc_dat, rd_req,
        input  busy, trig, cap_rdy, rd_vld, rd_dat, rd_last
    );

    modport slave (
        input  arm, abort, pre_len, trig_level, trig_edge,
        input  adc_req, adc_dat, rd_req,
        output busy, trig, cap_rdy, rd_vld, rd_dat, rd_last
    );
endinterface

// File: rtl/tsc_capture_buffer.sv
// Trigger-surround capture buffer for the TSC datapath.
// Once armed, it records ADC samples into a circular memory. A threshold event
// freezes a DEPTH-sample window made of pre_len older samples, the trigger
// sample and DEPTH-1-pre_len newer samples. The window is then streamed out
// oldest-first, one sample per honoured rd_req, with a one-cycle read latency.
module tsc_capture_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    tsc_capture_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TRIG_WAIT,
        S_POST,
        S_READ
    } state_e;

    // Sample store
    logic [DATA_W-1:0] mem [DEPTH];

    // Control state
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;

    // Configuration latched when an arm is accepted
    logic [ADDR_W-1:0] pre_len_q, pre_len_d;
    logic [DATA_W-1:0] trig_level_q, trig_level_d;
    logic              trig_edge_q, trig_edge_d;

    // Registered outputs
    logic              busy_q, busy_d;
    logic              trig_q, trig_d;
    logic              cap_rdy_q, cap_rdy_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_dat_q;

    // Per-cycle strobes
    logic wr_en;
    logic rd_en;
    logic rd_final;
    logic trig_hit;

    // Writes happen in every capturing state, reads only in READ, and abort
    // suppresses both on the edge where it is seen.
    always_comb begin
        wr_en    = bus.adc_req && !bus.abort &&
                   (state_q inside {S_PRE, S_TRIG_WAIT, S_POST});
        rd_en    = bus.rd_req && !bus.abort && (state_q == S_READ);
        rd_final = rd_en && (rd_cnt_q == '1);
        // Strict unsigned threshold test. In edge mode the previous sample
        // must also have been at or below the level, so a signal that is held
        // above the level never retriggers.
        trig_hit = wr_en && (state_q == S_TRIG_WAIT) &&
                   (bus.adc_dat > trig_level_q) &&
                   (!trig_edge_q || (prev_q <= trig_level_q));
    end

    // Next-state and next-output computation for the capture/readout sequence.
    always_comb begin
        // NOTE: every _d gets a default before any branch so that no path
        // leaves a signal unassigned, which would infer a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        post_d       = post_q;
        trig_ptr_d   = trig_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        prev_d       = prev_q;
        pre_len_d    = pre_len_q;
        trig_level_d = trig_level_q;
        trig_edge_d  = trig_edge_q;
        trig_d       = 1'b0;
        rd_vld_d     = rd_en;
        rd_last_d    = rd_final;

        // Common write side effects shared by PRE, TRIG_WAIT and POST
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            prev_d   = bus.adc_dat;
        end

        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.arm) begin
                        pre_len_d    = bus.pre_len;
                        trig_level_d = bus.trig_level;
                        trig_edge_d  = bus.trig_edge;
                        prev_d       = '0;
                        fill_d       = '0;
                        state_d      = (bus.pre_len == '0) ? S_TRIG_WAIT : S_PRE;
                    end
                end

                S_PRE: begin
                    if (wr_en) begin
                        fill_d = fill_q + ADDR_W'(1);
                        if (fill_d == pre_len_q) begin
                            state_d = S_TRIG_WAIT;
                        end
                    end
                end

                S_TRIG_WAIT: begin
                    if (trig_hit) begin
                        trig_d     = 1'b1;
                        trig_ptr_d = wr_ptr_q;
                        post_d     = ADDR_W'(DEPTH - 1) - pre_len_q;
                        if (pre_len_q == '1) begin
                            // No post samples: the window is complete already
                            state_d  = S_READ;
                            rd_ptr_d = wr_ptr_q - pre_len_q;
                            rd_cnt_d = '0;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end

                S_POST: begin
                    if (wr_en) begin
                        post_d = post_q - ADDR_W'(1);
                        if (post_q == ADDR_W'(1)) begin
                            state_d  = S_READ;
                            rd_ptr_d = trig_ptr_q - pre_len_q;
                            rd_cnt_d = '0;
                        end
                    end
                end

                S_READ: begin
                    if (rd_en) begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                        if (rd_final) begin
                            state_d = S_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Status flags follow the state being entered so they are registered
        busy_d    = state_d inside {S_PRE, S_TRIG_WAIT, S_POST};
        cap_rdy_d = (state_d == S_READ);
    end

    // State, pointer, configuration and output registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the edge.
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            post_q       <= '0;
            trig_ptr_q   <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            prev_q       <= '0;
            pre_len_q    <= '0;
            trig_level_q <= '0;
            trig_edge_q  <= 1'b0;
            busy_q       <= 1'b0;
            trig_q       <= 1'b0;
            cap_rdy_q    <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_dat_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            post_q       <= post_d;
            trig_ptr_q   <= trig_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            prev_q       <= prev_d;
            pre_len_q    <= pre_len_d;
            trig_level_q <= trig_level_d;
            trig_edge_q  <= trig_edge_d;
            busy_q       <= busy_d;
            trig_q       <= trig_d;
            cap_rdy_q    <= cap_rdy_d;
            rd_vld_q     <= rd_vld_d;
            rd_last_q    <= rd_last_d;
            if (rd_en) begin
                rd_dat_q <= mem[rd_ptr_q];
            end
        end
    end

    // Sample memory write port.
    always_ff @(posedge clk) begin
        // NOTE: the memory has no reset; a capture only ever reads locations
        // written since the arm, so stale contents are never observed.
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.adc_dat;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.trig    = trig_q;
    assign bus.cap_rdy = cap_rdy_q;
    assign bus.rd_vld  = rd_vld_q;
    assign bus.rd_dat  = rd_dat_q;
    assign bus.rd_last = rd_last_q;
endmodule

// File: tb/tb_tsc_capture_buffer.sv
// Self-checking bench for tsc_capture_buffer. A behavioural model keeps the
// list of samples accepted since the arm and derives the trigger index and the
// readout window from it. Every cycle the DUT outputs are compared with the
// model, and directed scenarios also pin literal values.
module tb_tsc_capture_buffer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tsc_capture_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

    tsc_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_samples[$];
    int                m_pre      = 0;
    logic [DATA_W-1:0] m_lvl      = '0;
    logic              m_edge     = 1'b0;
    int                m_trig_idx = -1;
    int                m_rd_n     = 0;
    int                m_phase    = 0;   // 0 idle, 1 capturing, 2 readout
    logic              e_busy = 0, e_trig = 0, e_cap_rdy = 0;
    logic              e_rd_vld = 0, e_rd_last = 0;
    logic [DATA_W-1:0] e_rd_dat = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_samples.delete(); m_trig_idx = -1; m_rd_n = 0;
                e_busy = 0; e_trig = 0; e_cap_rdy = 0;
                e_rd_vld = 0; e_rd_last = 0; e_rd_dat = '0;
            end else begin
                e_trig = 0; e_rd_vld = 0; e_rd_last = 0;
                if (ifc.abort) begin
                    m_phase = 0;
                end else if (m_phase == 0) begin
                    if (ifc.arm) begin
                        m_pre = int'(ifc.pre_len);
                        m_lvl = ifc.trig_level;
                        m_edge = ifc.trig_edge;
                        m_samples.delete();
                        m_trig_idx = -1;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (ifc.adc_req) begin
                        int idx;
                        logic [DATA_W-1:0] prev;
                        idx  = m_samples.size();
                        prev = (idx == 0) ? '0 : m_samples[idx-1];
                        m_samples.push_back(ifc.adc_dat);
                        if (m_trig_idx < 0 && idx >= m_pre && ifc.adc_dat > m_lvl &&
                            (!m_edge || prev <= m_lvl)) begin
                            m_trig_idx = idx;
                            e_trig = 1;
                        end
                        if (m_trig_idx >= 0 &&
                            m_samples.size() == m_trig_idx + DEPTH - m_pre) begin
                            m_phase = 2;
                            m_rd_n = 0;
                        end
                    end
                end else begin
                    if (ifc.rd_req) begin
                        e_rd_dat = m_samples[m_trig_idx - m_pre + m_rd_n];
                        e_rd_vld = 1;
                        m_rd_n++;
                        if (m_rd_n == DEPTH) begin
                            e_rd_last = 1;
                            m_phase = 0;
                        end
                    end
                end
                e_busy    = (m_phase == 1);
                e_cap_rdy = (m_phase == 2);
            end
        end
    end

    // ---------------- compare and monitor ----------------
    logic [DATA_W-1:0] rd_log[$];
    int                last_pos   = -1;
    int                trig_seen  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("status{busy,trig,cap_rdy,rd_vld,rd_last}",
                      {ifc.busy, ifc.trig, ifc.cap_rdy, ifc.rd_vld, ifc.rd_last},
                      {e_busy, e_trig, e_cap_rdy, e_rd_vld, e_rd_last});
                if (e_rd_vld) check("rd_dat", ifc.rd_dat, e_rd_dat);
                if (ifc.rd_vld) rd_log.push_back(ifc.rd_dat);
                if (ifc.rd_last) last_pos = rd_log.size();
                if (ifc.trig) trig_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- stimulus helpers ----------------
    logic [DATA_W-1:0] got[DEPTH];
    logic [DATA_W-1:0] ref_win[DEPTH];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_arm(input int pre, input int lvl, input logic edg);
        ifc.arm        = 1'b1;
        ifc.pre_len    = ADDR_W'(pre);
        ifc.trig_level = DATA_W'(lvl);
        ifc.trig_edge  = edg;
        tick();
        ifc.arm = 1'b0;
        rd_log.delete();
        last_pos  = -1;
        trig_seen = 0;
    endtask

    // One sample, then idle cycles; with noise, wrong-state arm/rd_req appear
    // in the idle cycles while a capture is running.
    task automatic send(input logic [DATA_W-1:0] d, input int gap, input bit noise);
        ifc.adc_req = 1'b1;
        ifc.adc_dat = d;
        tick();
        ifc.adc_req = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (noise && ifc.busy) begin
                ifc.arm = 1'b1; ifc.pre_len = 3; ifc.rd_req = 1'b1;
            end
            tick();
            ifc.arm = 1'b0; ifc.rd_req = 1'b0;
        end
    endtask

    // gap < 0 means random request gaps
    task automatic read_window(input int gap);
        int n = 0;
        while (rd_log.size() < DEPTH && n < 400) begin
            if (gap < 0)       ifc.rd_req = 1'($urandom_range(0, 1));
            else if (gap == 0) ifc.rd_req = 1'b1;
            else               ifc.rd_req = ((n % (gap + 1)) == 0);
            tick();
            n++;
        end
        ifc.rd_req = 1'b0;
        tick();
        check("read_window_size", rd_log.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) got[i] = (i < rd_log.size()) ? rd_log[i] : '0;
    endtask

    task automatic pulse_async_reset();
        #1 rst = 1'b1;
        #1 check("async_reset_outputs",
                 {ifc.busy, ifc.trig, ifc.cap_rdy, ifc.rd_vld, ifc.rd_last, ifc.rd_dat}, '0);
        tick();
        rst = 1'b0;
        tick();
        check("after_reset_idle", {ifc.busy, ifc.cap_rdy}, 2'b00);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        ifc.arm = 0; ifc.abort = 0; ifc.pre_len = '0; ifc.trig_level = '0;
        ifc.trig_edge = 0; ifc.adc_req = 0; ifc.adc_dat = '0; ifc.rd_req = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ifc.busy, ifc.trig, ifc.cap_rdy, ifc.rd_vld, ifc.rd_last, ifc.rd_dat}, '0);
        #1 rst = 1'b0;
        tick();

        // Level trigger on a ramp with 0xD6 injected as sample 20
        do_arm(8, 'hD5, 1'b0);
        for (int k = 0; k < 52; k++) send((k == 20) ? 8'hD6 : 8'(k), 0, 1'b0);
        read_window(0);
        check("lvl_trig_count", trig_seen, 1);
        check("lvl_first_pre", got[0], 8'd12);
        check("lvl_last_pre", got[7], 8'd19);
        check("lvl_trigger", got[8], 8'hD6);
        check("lvl_first_post", got[9], 8'd21);
        check("lvl_final", got[31], 8'd43);
        check("lvl_rd_last_pos", last_pos, DEPTH);
        for (int i = 0; i < DEPTH; i++) ref_win[i] = got[i];

        // Edge trigger: held above level must not fire; window wraps addresses
        do_arm(4, 'h80, 1'b1);
        repeat (14) send(8'h90, 0, 1'b0);
        check("edge_hold_no_trig", trig_seen, 0);
        check("edge_hold_busy", ifc.busy, 1'b1);
        send(8'h70, 0, 1'b0);
        send(8'h91, 0, 1'b0);
        for (int k = 0; k < 27; k++) send(8'(8'h40 + k), 0, 1'b0);
        read_window(1);
        check("edge_pre2", got[2], 8'h90);
        check("edge_pre3", got[3], 8'h70);
        check("edge_trigger", got[4], 8'h91);
        check("edge_post0", got[5], 8'h40);
        check("edge_final", got[31], 8'h5A);

        // pre_len = 0: first read is the trigger sample
        do_arm(0, 'h10, 1'b0);
        check("pre0_busy", ifc.busy, 1'b1);
        send(8'h05, 0, 1'b0);
        send(8'h20, 0, 1'b0);
        for (int k = 0; k < 31; k++) send(8'(8'h60 + k), 0, 1'b0);
        read_window(0);
        check("pre0_first_is_trigger", got[0], 8'h20);
        check("pre0_final", got[31], 8'h7E);

        // pre_len = 31: READ on the trigger write, last read is the trigger
        do_arm(31, 'h10, 1'b0);
        repeat (31) send(8'hF0, 0, 1'b0);
        send(8'h05, 0, 1'b0);
        send(8'h33, 0, 1'b0);
        check("pre31_cap_rdy_on_trigger", ifc.cap_rdy, 1'b1);
        read_window(0);
        check("pre31_first", got[0], 8'hF0);
        check("pre31_before_trigger", got[30], 8'h05);
        check("pre31_last_is_trigger", got[31], 8'h33);

        // abort together with arm in IDLE stays in IDLE
        ifc.arm = 1'b1; ifc.abort = 1'b1;
        tick();
        ifc.arm = 1'b0; ifc.abort = 1'b0;
        check("abort_arm_idle", ifc.busy, 1'b0);

        // abort in POST (with a concurrent sample)
        do_arm(2, 'h00, 1'b0);
        for (int k = 1; k <= 6; k++) send(8'(k), 0, 1'b0);
        ifc.abort = 1'b1; ifc.adc_req = 1'b1; ifc.adc_dat = 8'hEE;
        tick();
        ifc.abort = 1'b0; ifc.adc_req = 1'b0;
        check("abort_post_idle", {ifc.busy, ifc.cap_rdy}, 2'b00);

        // abort mid-READ after 5 reads
        do_arm(0, 'h00, 1'b0);
        for (int k = 1; k <= 32; k++) send(8'(k), 0, 1'b0);
        ifc.rd_req = 1'b1;
        repeat (5) tick();
        ifc.abort = 1'b1;
        tick();
        ifc.abort = 1'b0; ifc.rd_req = 1'b0;
        check("abort_read_cap_rdy", {ifc.busy, ifc.cap_rdy}, 2'b00);
        repeat (2) tick();
        check("abort_read_count", rd_log.size(), 5);
        check("abort_read_in_flight", (rd_log.size() == 5) ? rd_log[4] : 8'h00, 8'd5);

        // Re-arm with gapped samples, gapped reads and wrong-state noise
        do_arm(8, 'hD5, 1'b0);
        for (int k = 0; k < 44; k++) send((k == 20) ? 8'hD6 : 8'(k), 2, 1'b1);
        read_window(-1);
        for (int i = 0; i < DEPTH; i++) check($sformatf("gapped_vs_contig[%0d]", i), got[i], ref_win[i]);

        // Asynchronous reset mid-POST
        do_arm(4, 'h05, 1'b0);
        for (int k = 0; k < 10; k++) send(8'(k), 0, 1'b0);
        check("pre_reset_in_post", ifc.busy, 1'b1);
        pulse_async_reset();

        // Asynchronous reset mid-READ
        do_arm(0, 'h00, 1'b0);
        for (int k = 1; k <= 32; k++) send(8'(k), 0, 1'b0);
        ifc.rd_req = 1'b1;
        repeat (3) tick();
        ifc.rd_req = 1'b0;
        check("pre_reset_rd_vld", ifc.rd_vld, 1'b1);
        pulse_async_reset();

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            ifc.arm        = ($urandom_range(0, 19) == 0);
            ifc.pre_len    = ADDR_W'($urandom_range(0, DEPTH - 1));
            ifc.trig_level = DATA_W'($urandom_range(0, 255));
            ifc.trig_edge  = 1'($urandom_range(0, 1));
            ifc.abort      = ($urandom_range(0, 299) == 0);
            ifc.adc_req    = 1'($urandom_range(0, 1));
            ifc.adc_dat    = DATA_W'($urandom_range(0, 255));
            ifc.rd_req     = ($urandom_range(0, 2) != 0);
            tick();
        end
        ifc.arm = 0; ifc.abort = 0; ifc.adc_req = 0; ifc.rd_req = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
